// File: rtl/serial_sub_sequencer_if.sv
// Handshake and operand/result bundle for serial_sub_sequencer.
// The abort signal exists only when SERIAL_SUB_ABORT_EN is defined.
interface serial_sub_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             a_gt_b;
  logic             a_eq_b;
  logic             a_lt_b;
`ifdef SERIAL_SUB_ABORT_EN
  logic             abort;
`endif

  modport master (
    output start, a, b,
`ifdef SERIAL_SUB_ABORT_EN
    output abort,
`endif
    input  busy, done, diff, borrow_out, a_gt_b, a_eq_b, a_lt_b
  );

  modport slave (
    input  start, a, b,
`ifdef SERIAL_SUB_ABORT_EN
    input  abort,
`endif
    output busy, done, diff, borrow_out, a_gt_b, a_eq_b, a_lt_b
  );
endinterface

// File: rtl/serial_sub_sequencer.sv
// Bit-serial subtractor / unsigned magnitude comparator.
// One full-subtractor cell plus a registered borrow, operands consumed LSB first.
// Optional feature macro: SERIAL_SUB_ABORT_EN (adds an abort input to the bus).
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// SHIFT | one bit per clock through the subtractor cell
// DONE  | one-cycle done pulse, results valid
module serial_sub_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_sub_sequencer_if.slave sub_if
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic             abort_w;
  logic             bit_d;
  logic             br_nxt;
  logic [WIDTH-1:0] diff_nxt;
  logic             last_bit;
  logic             zero_nxt;

`ifdef SERIAL_SUB_ABORT_EN
  assign abort_w = sub_if.abort;
`else
  assign abort_w = 1'b0;
`endif

  // Full-subtractor cell on the current LSBs and the running borrow
  assign bit_d    = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
  assign br_nxt   = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
  assign diff_nxt = {bit_d, dsr_q[WIDTH-1:1]};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign zero_nxt = (diff_nxt == '0);

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    dsr_d    = dsr_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;

    case (state_q)
      IDLE: begin
        if (sub_if.start) begin
          state_d = SHIFT;
          a_sr_d  = sub_if.a;
          b_sr_d  = sub_if.b;
          dsr_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (abort_w) begin
          // Discard the operation; published results stay at the last completion
          state_d = IDLE;
        end else begin
          a_sr_d = a_sr_q >> 1;
          b_sr_d = b_sr_q >> 1;
          br_d   = br_nxt;
          dsr_d  = diff_nxt;
          cnt_d  = cnt_q + CW'(1);
          if (last_bit) begin
            state_d  = DONE;
            done_d   = 1'b1;
            diff_d   = diff_nxt;
            borrow_d = br_nxt;
            lt_d     = br_nxt;
            eq_d     = zero_nxt;
            gt_d     = ~br_nxt & ~zero_nxt;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand/difference shift registers, running borrow and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_q <= '0;
      b_sr_q <= '0;
      dsr_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      a_sr_q <= a_sr_d;
      b_sr_q <= b_sr_d;
      dsr_q  <= dsr_d;
      br_q   <= br_d;
      cnt_q  <= cnt_d;
    end
  end

  // Registered outputs; results change only on a completing edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
    end
  end

  assign sub_if.busy       = busy_q;
  assign sub_if.done       = done_q;
  assign sub_if.diff       = diff_q;
  assign sub_if.borrow_out = borrow_q;
  assign sub_if.a_gt_b     = gt_q;
  assign sub_if.a_eq_b     = eq_q;
  assign sub_if.a_lt_b     = lt_q;
endmodule

// File: tb/tb_serial_sub_sequencer.sv
// Directed bench for serial_sub_sequencer (WIDTH = 8).
module tb_serial_sub_sequencer;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  serial_sub_sequencer_if #(.WIDTH(8)) bus ();

  serial_sub_sequencer #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sub_if (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single operation with start pulsed for one cycle; checks latency and results
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] e_diff, input logic e_br,
                        input logic e_gt, input logic e_eq, input logic e_lt);
    int lat;
    bit found;
    lat   = 0;
    found = 0;
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      lat++;
      if (bus.done) found = 1;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_diff"}, 32'(bus.diff), 32'(e_diff));
    chk({tag, "_borrow"}, 32'(bus.borrow_out), 32'(e_br));
    chk({tag, "_gt"}, 32'(bus.a_gt_b), 32'(e_gt));
    chk({tag, "_eq"}, 32'(bus.a_eq_b), 32'(e_eq));
    chk({tag, "_lt"}, 32'(bus.a_lt_b), 32'(e_lt));
    chk({tag, "_busy_in_done"}, 32'(bus.busy), 32'd1);
    tick();
    chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    chk({tag, "_busy_dropped"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_diff"}, 32'(bus.diff), 32'd0);
    chk({tag, "_borrow"}, 32'(bus.borrow_out), 32'd0);
    chk({tag, "_gt"}, 32'(bus.a_gt_b), 32'd0);
    chk({tag, "_eq"}, 32'(bus.a_eq_b), 32'd0);
    chk({tag, "_lt"}, 32'(bus.a_lt_b), 32'd0);
  endtask

  initial begin
    int  rise1, rise2, done_cnt, dcnt;
    bit  prev_busy;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SERIAL_SUB_ABORT_EN
    bus.abort = 1'b0;
`endif

    // Reset state
    #2 rst_n = 1'b0;
    #10;
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk_all_zero("idle_after_reset");

    // Basic operations
    run_op("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("sub_a5_a5", 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("sub_00_ff", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);

    // Start held: operands changed mid-SHIFT, back-to-back accept spacing
    rise1     = -1;
    rise2     = -1;
    done_cnt  = 0;
    prev_busy = bus.busy;
    bus.a     = 8'h30;
    bus.b     = 8'h10;
    bus.start = 1'b1;
    for (int i = 1; i <= 40 && done_cnt < 2; i++) begin
      tick();
      if (bus.busy && !prev_busy) begin
        if (rise1 < 0) rise1 = i;
        else if (rise2 < 0) begin
          rise2     = i;
          bus.start = 1'b0;
        end
      end
      if (rise1 >= 0 && i == rise1 + 3) begin
        bus.a = 8'hFF;
        bus.b = 8'h01;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          chk("held_first_diff", 32'(bus.diff), 32'h20);
          chk("held_first_gt", 32'(bus.a_gt_b), 32'd1);
        end else begin
          chk("held_second_diff", 32'(bus.diff), 32'hFE);
        end
      end
      prev_busy = bus.busy;
    end
    bus.start = 1'b0;
    chk("held_done_count", 32'(done_cnt), 32'd2);
    chk("held_accept_spacing", 32'(rise2 - rise1), 32'd10);
    repeat (2) tick();

    // Reset during bit 4 of 0x80 - 0x01
    bus.a     = 8'h80;
    bus.b     = 8'h01;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("post_reset_busy", 32'(bus.busy), 32'd0);
    run_op("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef SERIAL_SUB_ABORT_EN
    // Abort at bit 3 of 0x10 - 0x20; prior result (0x7F) must persist
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_diff", 32'(bus.diff), 32'h7F);
    chk("abort_gt", 32'(bus.a_gt_b), 32'd1);
    chk("abort_lt", 32'(bus.a_lt_b), 32'd0);
    chk("abort_borrow", 32'(bus.borrow_out), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    run_op("post_abort", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1);
`else
    dcnt = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
